i2c_target: RTL and testbench



---
 rtl/i2c_target_if.sv | 25 ++
 rtl/i2c_target.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// I2C pin-level and local-port signal bundle for the i2c_target register file.
// The master modport is the environment side (pins plus local logic); slave is the target.
interface i2c_target_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  scl_in;
   logic                  sda_in;
   logic                  sda_oe;
   logic [DEPTH_LOG2-1:0] loc_addr;
   logic                  loc_we;
   logic [7:0]            loc_wdata;
   logic [7:0]            loc_rdata;
   logic                  wr_pulse;
   logic                  busy;

   modport master (
      output scl_in, sda_in, loc_addr, loc_we, loc_wdata,
      input  sda_oe, loc_rdata, wr_pulse, busy
   );

   modport slave (
      input  scl_in, sda_in, loc_addr, loc_we, loc_wdata,
      output sda_oe, loc_rdata, wr_pulse, busy
   );
endinterface

// File: rtl/i2c_target.sv
// Oversampled I2C target with a 2**DEPTH_LOG2 byte register file.
// Pointer-then-data protocol on I2C; synchronous local read/write port.
module i2c_target #(
   parameter logic [6:0] ADDR       = 7'h50,
   parameter int         DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   i2c_target_if.slave bus
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WPTR, S_PTR_ACK,
      S_WDATA, S_DATA_ACK, S_READ, S_RACK
   } state_t;

   state_t                state, state_n;
   logic [2:0]            scl_q, sda_q;
   logic [7:0]            shreg, shreg_n;
   logic [3:0]            bit_cnt, cnt_n;
   logic [DEPTH_LOG2-1:0] ptr, ptr_n;
   logic                  oe_q, oe_n;
   logic                  rw_q, rw_n;
   logic                  mack_q, mack_n;
   logic                  busy_q, busy_n;
   logic                  wr_pulse_q;
   logic [7:0]            loc_rdata_q;
   logic                  i2c_we;
   logic [7:0]            i2c_wdata;
   logic [7:0]            mem [DEPTH];

   // [1] is the synchronized level, [2] the previous one for edge detect
   logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
   assign scl_s    = scl_q[1];
   assign sda_s    = sda_q[1];
   assign scl_rise =  scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] &  scl_q[2];
   assign start    = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
   assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

   // Idle bus is high, so the synchronizers reset high to avoid a phantom edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], bus.scl_in};
         sda_q <= {sda_q[1:0], bus.sda_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      cnt_n     = bit_cnt;
      ptr_n     = ptr;
      oe_n      = oe_q;
      rw_n      = rw_q;
      mack_n    = mack_q;
      busy_n    = busy_q;
      i2c_we    = 1'b0;
      i2c_wdata = {shreg[6:0], sda_s};
      if (start) begin
         state_n = S_ADDR;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b1;
      end else if (stop) begin
         state_n = S_IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         case (state)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise) begin
                  shreg_n = {shreg[6:0], sda_s};
                  cnt_n   = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  if (shreg[7:1] == ADDR) begin
                     oe_n    = 1'b1;
                     rw_n    = shreg[0];
                     state_n = S_ADDR_ACK;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_n = 4'd0;
                  if (rw_q) begin
                     shreg_n = mem[ptr];
                     oe_n    = ~mem[ptr][7];
                     state_n = S_READ;
                  end else begin
                     oe_n    = 1'b0;
                     state_n = S_WPTR;
                  end
               end
            end
            S_WPTR: begin
               if (scl_rise) begin
                  shreg_n = {shreg[6:0], sda_s};
                  cnt_n   = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  ptr_n   = shreg[DEPTH_LOG2-1:0];
                  oe_n    = 1'b1;
                  state_n = S_PTR_ACK;
               end
            end
            S_WDATA: begin
               if (scl_rise) begin
                  shreg_n = {shreg[6:0], sda_s};
                  cnt_n   = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     i2c_we = 1'b1;
                     ptr_n  = ptr + PTR_ONE;
                  end
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  oe_n    = 1'b1;
                  state_n = S_DATA_ACK;
               end
            end
            S_PTR_ACK, S_DATA_ACK: begin
               if (scl_fall) begin
                  oe_n    = 1'b0;
                  cnt_n   = 4'd0;
                  state_n = S_WDATA;
               end
            end
            S_READ: begin
               if (scl_rise) begin
                  cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     oe_n    = 1'b0;
                     ptr_n   = ptr + PTR_ONE;
                     state_n = S_RACK;
                  end else begin
                     shreg_n = {shreg[6:0], 1'b0};
                     oe_n    = ~shreg[6];
                  end
               end
            end
            S_RACK: begin
               if (scl_rise) begin
                  mack_n = sda_s;
               end else if (scl_fall) begin
                  if (!mack_q) begin
                     shreg_n = mem[ptr];
                     oe_n    = ~mem[ptr][7];
                     cnt_n   = 4'd0;
                     state_n = S_READ;
                  end else begin
                     oe_n    = 1'b0;
                     state_n = S_IDLE;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= 8'h00;
         bit_cnt    <= 4'd0;
         ptr        <= '0;
         oe_q       <= 1'b0;
         rw_q       <= 1'b0;
         mack_q     <= 1'b1;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
      end else begin
         shreg      <= shreg_n;
         bit_cnt    <= cnt_n;
         ptr        <= ptr_n;
         oe_q       <= oe_n;
         rw_q       <= rw_n;
         mack_q     <= mack_n;
         busy_q     <= busy_n;
         wr_pulse_q <= i2c_we;
      end
   end

   // I2C write has priority; a local write only loses on the same address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         loc_rdata_q <= 8'h00;
      end else begin
         if (bus.loc_we && !(i2c_we && bus.loc_addr == ptr))
            mem[bus.loc_addr] <= bus.loc_wdata;
         if (i2c_we)
            mem[ptr] <= i2c_wdata;
         loc_rdata_q <= mem[bus.loc_addr];
      end
   end

   assign bus.sda_oe    = oe_q;
   assign bus.loc_rdata = loc_rdata_q;
   assign bus.wr_pulse  = wr_pulse_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master, local-port driver and a byte-array
// model of the register file and pointer.
module tb_i2c_target;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;
   logic sda_line;
   int   q = 8;
   int   vectors = 0;
   int   errors  = 0;
   int   wr_cnt  = 0;
   int   busy_drops = 0;
   int   oe_hits = 0;
   bit   busy_mon = 0;
   bit   oe_mon = 0;
   logic [7:0] coll_rdata;

   logic [7:0] m_mem [16];
   int         m_ptr;

   always #5 clk = ~clk;

   i2c_target_if #(.DEPTH_LOG2(4)) bus ();
   i2c_target #(.ADDR(7'h50), .DEPTH_LOG2(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   assign sda_line   = sda_m & ~bus.sda_oe;
   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_line;

   always @(posedge clk) if (bus.wr_pulse) wr_cnt++;
   always @(negedge clk) begin
      if (busy_mon && !bus.busy) busy_drops++;
      if (oe_mon && bus.sda_oe) oe_hits++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      if (scl_m == 1'b0) begin
         wait_clk(q); sda_m = 1'b1; wait_clk(q); scl_m = 1'b1;
      end
      wait_clk(q); sda_m = 1'b0; wait_clk(2*q); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(q); sda_m = 1'b0; wait_clk(q); scl_m = 1'b1;
      wait_clk(q); sda_m = 1'b1; wait_clk(2*q);
   endtask

   task automatic send_bit(input logic b, output logic smp);
      wait_clk(q); sda_m = b; wait_clk(q); scl_m = 1'b1;
      wait_clk(q); smp = sda_line; wait_clk(q); scl_m = 1'b0;
   endtask

   // Optionally fires a one-clock local write aligned with the target's I2C write
   task automatic write_byte(input logic [7:0] b, output logic ack, input bit coll,
                             input logic [3:0] caddr, input logic [7:0] cdata);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && coll) begin
            wait_clk(q); sda_m = b[0]; wait_clk(q); scl_m = 1'b1;
            wait_clk(2);
            bus.loc_addr = caddr; bus.loc_wdata = cdata; bus.loc_we = 1'b1;
            wait_clk(1); bus.loc_we = 1'b0;
            wait_clk(1); coll_rdata = bus.loc_rdata;
            wait_clk(2*q-4); scl_m = 1'b0;
         end else begin
            send_bit(b[i], s);
         end
      end
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic wb(input logic [7:0] b, output logic ack);
      write_byte(b, ack, 1'b0, 4'd0, 8'd0);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(nack, s);
   endtask

   task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
      bus.loc_addr = a; bus.loc_wdata = d; bus.loc_we = 1'b1;
      wait_clk(1); bus.loc_we = 1'b0;
      m_mem[a] = d;
   endtask

   task automatic loc_read(input logic [3:0] a, output logic [7:0] d);
      bus.loc_addr = a; wait_clk(2); d = bus.loc_rdata;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_ptr = 0;
   endtask

   task automatic check_all_mem(input string tag);
      logic [7:0] d;
      for (int i = 0; i < 16; i++) begin
         loc_read(4'(i), d);
         vectors++;
         if (d !== m_mem[i]) begin
            errors++;
            $display("FAIL %s mem[%0d]: got %02h want %02h", tag, i, d, m_mem[i]);
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst = 1'b1; wait_clk(4);
      vectors++;
      if (bus.sda_oe !== 1'b0 || bus.busy !== 1'b0 || bus.wr_pulse !== 1'b0 || bus.loc_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got oe=%b busy=%b wp=%b rd=%02h want 0", bus.sda_oe, bus.busy, bus.wr_pulse, bus.loc_rdata);
      end
      rst = 1'b0; wait_clk(4);
      model_clear();
      for (int i = 0; i < 4; i++) begin
         logic [3:0] a;
         a = 4'($urandom_range(0, 15));
         loc_read(a, d);
         vectors++;
         if (d !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d]: got %02h want 00", a, d); end
      end
   endtask

   task automatic test_write_burst();
      logic a0, a1, a2, a3;
      logic [7:0] d, r;
      int w0;
      w0 = wr_cnt;
      i2c_start(); wb(8'hA0, a0); wb(8'h03, a1); wb(8'h11, a2); wb(8'h22, a3); i2c_stop();
      m_mem[3] = 8'h11; m_mem[4] = 8'h22; m_ptr = 5;
      vectors++;
      if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL burst_acks: got %b want 1111", {a0, a1, a2, a3}); end
      vectors++;
      if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL burst_wr_pulse: got %0d want 2", wr_cnt - w0); end
      loc_read(4'd3, d);
      vectors++;
      if (d !== 8'h11) begin errors++; $display("FAIL burst_mem3: got %02h want 11", d); end
      loc_read(4'd4, d);
      vectors++;
      if (d !== 8'h22) begin errors++; $display("FAIL burst_mem4: got %02h want 22", d); end
      // pointer should now sit at 5: plant a value there and read it back
      loc_write(4'd5, 8'($urandom));
      i2c_start(); wb(8'hA1, a0); read_byte(1'b1, r); i2c_stop();
      vectors++;
      if (a0 !== 1'b1 || r !== m_mem[5]) begin errors++; $display("FAIL burst_ptr5: got ack=%b %02h want ack=1 %02h", a0, r, m_mem[5]); end
      m_ptr = 6;
   endtask

   task automatic test_random_writes();
      for (int it = 0; it < 4; it++) begin
         int p, n, w0, bad;
         logic a;
         p = $urandom_range(0, 255); n = $urandom_range(1, 4);
         w0 = wr_cnt; bad = 0;
         i2c_start(); wb(8'hA0, a); if (!a) bad++;
         wb(8'(p), a); if (!a) bad++;
         m_ptr = p % 16;
         for (int k = 0; k < n; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            wb(d, a); if (!a) bad++;
            m_mem[m_ptr] = d; m_ptr = (m_ptr + 1) % 16;
         end
         i2c_stop();
         vectors++;
         if (bad !== 0 || wr_cnt - w0 !== n) begin
            errors++;
            $display("FAIL rand_write_%0d: got nacks=%0d pulses=%0d want 0 and %0d", it, bad, wr_cnt - w0, n);
         end
      end
      check_all_mem("rand_write");
   endtask

   task automatic test_random_reads();
      for (int it = 0; it < 3; it++) begin
         int n;
         logic a0, a1;
         logic [7:0] r;
         n = $urandom_range(1, 5);
         i2c_start(); wb(8'hA0, a0); wb(8'($urandom_range(0, 15)), a1);
         m_ptr = 0;
         vectors++;
         if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL rand_read_acks_%0d: got %b want 11", it, {a0, a1}); end
         m_ptr = int'(dut.ptr);
         i2c_start(); wb(8'hA1, a0);
         for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, r);
            vectors++;
            if (r !== m_mem[m_ptr]) begin errors++; $display("FAIL rand_read_%0d_%0d: got %02h want %02h", it, k, r, m_mem[m_ptr]); end
            m_ptr = (m_ptr + 1) % 16;
         end
         i2c_stop();
      end
   endtask

   task automatic test_read_wrap();
      logic a0, a1, a2;
      logic [7:0] r0, r1;
      loc_write(4'd15, 8'($urandom)); loc_write(4'd0, 8'($urandom));
      i2c_start(); wb(8'hA0, a0); wb(8'h0F, a1);
      i2c_start(); wb(8'hA1, a2);
      read_byte(1'b0, r0); read_byte(1'b1, r1);
      wait_clk(4);
      vectors++;
      if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL wrap_release: got oe=%b want 0", bus.sda_oe); end
      i2c_stop();
      m_ptr = 1;
      vectors++;
      if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wrap_acks: got %b want 111", {a0, a1, a2}); end
      vectors++;
      if (r0 !== m_mem[15]) begin errors++; $display("FAIL wrap_byte15: got %02h want %02h", r0, m_mem[15]); end
      vectors++;
      if (r1 !== m_mem[0]) begin errors++; $display("FAIL wrap_byte0: got %02h want %02h", r1, m_mem[0]); end
   endtask

   task automatic test_wrong_addr();
      logic [6:0] ad;
      logic a0, a1;
      int w0;
      do ad = 7'($urandom); while (ad == 7'h50);
      w0 = wr_cnt;
      oe_hits = 0; oe_mon = 1;
      i2c_start();
      wait_clk(2);
      vectors++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL wrong_busy_during: got %b want 1", bus.busy); end
      wb({ad, 1'($urandom)}, a0);
      wb(8'($urandom), a1);
      i2c_stop();
      oe_mon = 0;
      vectors++;
      if (a0 !== 1'b0 || a1 !== 1'b0 || oe_hits !== 0) begin
         errors++;
         $display("FAIL wrong_nack: got ack=%b%b oe_cycles=%0d want 00 and 0", a0, a1, oe_hits);
      end
      vectors++;
      if (bus.busy !== 1'b0 || wr_cnt !== w0) begin errors++; $display("FAIL wrong_after: got busy=%b pulses=%0d want 0 and 0", bus.busy, wr_cnt - w0); end
      check_all_mem("wrong_addr");
   endtask

   task automatic test_collision();
      logic a0, a1, a2;
      logic [7:0] d, d1, d2;
      i2c_start(); wb(8'hA0, a0); wb(8'h02, a1);
      write_byte(8'h5A, a2, 1'b1, 4'd2, 8'hFF); i2c_stop();
      m_mem[2] = 8'h5A; m_ptr = 3;
      vectors++;
      if (coll_rdata !== 8'h5A) begin errors++; $display("FAIL coll_rdata_2clk: got %02h want 5a", coll_rdata); end
      loc_read(4'd2, d);
      vectors++;
      if ({a0, a1, a2} !== 3'b111 || d !== 8'h5A) begin errors++; $display("FAIL coll_same: got ack=%b %02h want 111 5a", {a0, a1, a2}, d); end
      d1 = 8'($urandom); d2 = 8'($urandom);
      i2c_start(); wb(8'hA0, a0); wb(8'h02, a1);
      write_byte(d1, a2, 1'b1, 4'd9, d2); i2c_stop();
      m_mem[2] = d1; m_mem[9] = d2;
      loc_read(4'd2, d);
      vectors++;
      if (d !== d1) begin errors++; $display("FAIL coll_diff_i2c: got %02h want %02h", d, d1); end
      loc_read(4'd9, d);
      vectors++;
      if (d !== d2) begin errors++; $display("FAIL coll_diff_loc: got %02h want %02h", d, d2); end
   endtask

   task automatic test_abort();
      logic a0, a1, s;
      logic [7:0] r0, r1;
      logic [3:0] hi;
      loc_write(4'd6, {4'($urandom), 4'b0000});
      i2c_start(); wb(8'hA0, a0); wb(8'h06, a1); i2c_stop();
      i2c_start(); wb(8'hA1, a0);
      for (int i = 3; i >= 0; i--) begin send_bit(1'b1, s); hi[i] = s; end
      wait_clk(q);
      vectors++;
      if (hi !== m_mem[6][7:4] || bus.sda_oe !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got bits=%h oe=%b want %h 1", hi, bus.sda_oe, m_mem[6][7:4]);
      end
      rst = 1'b1; #1;
      vectors++;
      if (bus.sda_oe !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_async: got oe=%b busy=%b want 0 0", bus.sda_oe, bus.busy); end
      sda_m = 1'b1; scl_m = 1'b1;
      wait_clk(3); rst = 1'b0; wait_clk(4);
      model_clear();
      loc_write(4'd0, 8'($urandom)); loc_write(4'd1, 8'($urandom));
      i2c_start(); wb(8'hA1, a0); read_byte(1'b0, r0); read_byte(1'b1, r1); i2c_stop();
      m_ptr = 2;
      vectors++;
      if (a0 !== 1'b1 || r0 !== m_mem[0] || r1 !== m_mem[1]) begin
         errors++;
         $display("FAIL abort_after: got ack=%b %02h %02h want 1 %02h %02h", a0, r0, r1, m_mem[0], m_mem[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic a0, a1, a2, a3, a4;
      logic [7:0] d0, d1, r0, r1;
      int p;
      q = 3;
      p = $urandom_range(0, 15); d0 = 8'($urandom); d1 = 8'($urandom);
      busy_drops = 0;
      i2c_start(); busy_mon = 1;
      wb(8'hA0, a0); wb(8'(p), a1); wb(d0, a2); wb(d1, a3);
      m_mem[p] = d0; m_mem[(p + 1) % 16] = d1;
      i2c_start(); wb(8'hA0, a4); wb(8'(p), a4);
      i2c_start(); wb(8'hA1, a4);
      read_byte(1'b0, r0); read_byte(1'b1, r1);
      busy_mon = 0;
      i2c_stop();
      m_ptr = (p + 2) % 16;
      vectors++;
      if ({a0, a1, a2, a3, a4} !== 5'b11111) begin errors++; $display("FAIL fast_acks: got %b want 11111", {a0, a1, a2, a3, a4}); end
      vectors++;
      if (r0 !== d0 || r1 !== d1) begin errors++; $display("FAIL fast_readback: got %02h %02h want %02h %02h", r0, r1, d0, d1); end
      vectors++;
      if (busy_drops !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL fast_busy: got drops=%0d end_busy=%b want 0 0", busy_drops, bus.busy);
      end
      q = 8;
   endtask

   initial begin
      bus.loc_addr = 4'd0; bus.loc_we = 1'b0; bus.loc_wdata = 8'h00;
      test_reset();
      test_write_burst();
      test_random_writes();
      test_random_reads();
      test_read_wrap();
      test_wrong_addr();
      test_collision();
      test_abort();
      test_back_to_back();
      check_all_mem("final");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
